// File: rtl/m_cluster_dram_bridge.sv
// Bridges the cluster's single selected-hart memory request onto a valid/ready DRAM port,
// with byte-lane alignment, load extension and misalignment rejection. Optional macro: BRIDGE_TIMEOUT_EN.
module m_cluster_dram_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        w_req_re,
    input  logic        w_req_we,
    input  logic [31:0] w_req_addr,
    input  logic [2:0]  w_req_ctrl,
    input  logic [31:0] w_req_wdata,
    output logic        w_busy,
    output logic        w_resp_valid,
    output logic [31:0] w_rdata,
    output logic        w_misaligned,
    output logic        w_dram_valid,
    input  logic        w_dram_ready,
    output logic        w_dram_we,
    output logic [31:0] w_dram_addr,
    output logic [31:0] w_dram_wdata,
    output logic [3:0]  w_dram_be,
    input  logic        w_dram_rvalid,
    input  logic [31:0] w_dram_rdata,
`ifdef BRIDGE_TIMEOUT_EN
    output logic        w_timeout,
`endif
    output logic [1:0]  w_dbg_state
);

    // Handshake: a DRAM command transfers on a cycle with w_dram_valid && w_dram_ready and is held
    // stable until then; read data returns later on w_dram_rvalid, never in the same cycle as ready.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state, next_state;
    logic        req, mis, fire, rd_done, abort;
    logic        we_q, mis_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q;
    logic [31:0] lane, ext, st_data;
    logic [3:0]  st_be;

    assign req         = w_req_re | w_req_we;
    assign fire        = (state == S_REQ) && w_dram_ready;
    assign rd_done     = (state == S_WAIT_R) && w_dram_rvalid;
    assign w_dbg_state = state;

    always_comb begin
        case (w_req_ctrl)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = w_req_addr[0];
            3'b010:         mis = |w_req_addr[1:0];
            default:        mis = 1'b1;
        endcase
    end

    // Store lane placement; reads always enable the full word.
    always_comb begin
        st_be   = 4'b1111;
        st_data = w_req_wdata;
        case (w_req_ctrl[1:0])
            2'b00: begin
                st_be   = 4'b0001 << w_req_addr[1:0];
                st_data = {4{w_req_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = w_req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{w_req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!w_req_we) st_be = 4'b1111;
    end

    assign lane = w_dram_rdata >> {off_q, 3'b000};

    always_comb begin
        case (ctrl_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ext = {24'd0, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ext = {16'd0, lane[15:0]};
            default: ext = w_dram_rdata;
        endcase
    end

`ifdef BRIDGE_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        timeout_q;

    // >= so a read accepted on the last allowed REQ cycle still aborts in WAIT_R.
    assign abort = ((state == S_REQ && !w_dram_ready) || (state == S_WAIT_R && !w_dram_rvalid))
                   && (to_cnt >= 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != S_REQ && next_state == S_REQ)
                to_cnt <= '0;
            else if (state == S_REQ || state == S_WAIT_R)
                to_cnt <= to_cnt + 32'd1;
            if (abort) timeout_q <= 1'b1;
        end
    end

    assign w_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign abort              = 1'b0;
    assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (req) next_state = mis ? S_DONE : S_REQ;
            S_REQ: begin
                if (fire)       next_state = we_q ? S_DONE : S_WAIT_R;
                else if (abort) next_state = S_DONE;
            end
            S_WAIT_R: if (w_dram_rvalid || abort) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_dram_valid = (state == S_REQ);
        w_dram_we    = we_q;
        w_resp_valid = (state == S_DONE) && !mis_q;
        w_misaligned = (state == S_DONE) && mis_q;
        w_busy       = !RST && ((state == S_REQ) || (state == S_WAIT_R) || (state == S_IDLE && req));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q         <= 1'b0;
            mis_q        <= 1'b0;
            ctrl_q       <= 3'd0;
            off_q        <= 2'd0;
            w_dram_addr  <= '0;
            w_dram_wdata <= '0;
            w_dram_be    <= '0;
            w_rdata      <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                we_q         <= w_req_we;
                mis_q        <= mis;
                ctrl_q       <= w_req_ctrl;
                off_q        <= w_req_addr[1:0];
                w_dram_addr  <= {w_req_addr[31:2], 2'b00};
                w_dram_wdata <= st_data;
                w_dram_be    <= st_be;
            end
            if (rd_done)    w_rdata <= ext;
            else if (abort) w_rdata <= 32'hDEADBEEF;
        end
    end

endmodule

// File: tb/tb_m_cluster_dram_bridge.sv
// Self-checking bench for m_cluster_dram_bridge: directed corner cases plus randomized
// transactions checked against an arithmetic reference model.
module tb_m_cluster_dram_bridge;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        w_req_re = 1'b0, w_req_we = 1'b0;
    logic [31:0] w_req_addr = '0, w_req_wdata = '0;
    logic [2:0]  w_req_ctrl = '0;
    logic        w_busy, w_resp_valid, w_misaligned, w_dram_valid, w_dram_we;
    logic [31:0] w_rdata, w_dram_addr, w_dram_wdata;
    logic [3:0]  w_dram_be;
    logic        w_dram_ready = 1'b0, w_dram_rvalid = 1'b0;
    logic [31:0] w_dram_rdata = '0;
    logic [1:0]  w_dbg_state;
`ifdef BRIDGE_TIMEOUT_EN
    logic        w_timeout;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    m_cluster_dram_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .w_req_re(w_req_re), .w_req_we(w_req_we), .w_req_addr(w_req_addr),
        .w_req_ctrl(w_req_ctrl), .w_req_wdata(w_req_wdata),
        .w_busy(w_busy), .w_resp_valid(w_resp_valid), .w_rdata(w_rdata),
        .w_misaligned(w_misaligned), .w_dram_valid(w_dram_valid), .w_dram_ready(w_dram_ready),
        .w_dram_we(w_dram_we), .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
        .w_dram_be(w_dram_be), .w_dram_rvalid(w_dram_rvalid), .w_dram_rdata(w_dram_rdata),
`ifdef BRIDGE_TIMEOUT_EN
        .w_timeout(w_timeout),
`endif
        .w_dbg_state(w_dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] c);
        case (c[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_mis(input logic [2:0] c, input logic [31:0] a);
        if (c == 3'b011 || c == 3'b110 || c == 3'b111) return 1'b1;
        return (a % nbytes(c)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] w);
        int          n;
        logic [31:0] v, lim;
        n = nbytes(c);
        if (n == 4) return w;
        v   = (w >> (8 * (a % 4))) % (32'h1 << (8 * n));
        lim = 32'h1 << (8 * n - 1);
        if (c[2] == 1'b0 && v >= lim) v = v - (32'h1 << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] c, input logic [31:0] a);
        logic [7:0] t;
        t = 8'(((1 << nbytes(c)) - 1) << (a % 4));
        return t[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] c, input logic [31:0] w);
        case (nbytes(c))
            1:       return (w & 32'hFF) * 32'h0101_0101;
            2:       return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    // ---------------- driver: one full transaction ----------------
    task automatic run_txn(input bit re, input bit we, input logic [31:0] addr,
                           input logic [2:0] ctrl, input logic [31:0] wdata,
                           input logic [31:0] rword, input int rd, input int rv,
                           input bit b2b, input string tag);
        bit          is_wr, mis;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_be;
        is_wr  = we;
        mis    = exp_mis(ctrl, addr);
        e_addr = addr & 32'hFFFF_FFFC;
        e_be   = is_wr ? exp_be(ctrl, addr) : 4'hF;
        e_wd   = exp_wdata(ctrl, wdata);
        w_req_re = re; w_req_we = we; w_req_addr = addr; w_req_ctrl = ctrl; w_req_wdata = wdata;
        if (!is_wr && !mis) exp_q.push_back(exp_load(ctrl, addr, rword));
        @(negedge CLK);
        n_vec++;
        if ({w_busy, w_resp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL %s req_cycle: busy=%b resp=%b, want busy=1 resp=0", tag, w_busy, w_resp_valid);
        end
        @(posedge CLK); #1;
        if (mis) begin
            w_req_re = 1'b0; w_req_we = 1'b0;
            @(negedge CLK);
            n_vec++;
            if ({w_misaligned, w_resp_valid, w_busy, w_dram_valid} !== 4'b1000) begin
                n_err++;
                $display("FAIL %s misaligned: mis=%b resp=%b busy=%b valid=%b, want 1 0 0 0",
                         tag, w_misaligned, w_resp_valid, w_busy, w_dram_valid);
            end
        end else begin
            w_req_addr = $urandom; w_req_wdata = $urandom; w_req_ctrl = 3'($urandom_range(0, 7));
            for (int i = 0; i <= rd; i++) begin
                w_dram_ready = (i == rd);
                @(negedge CLK);
                n_vec++;
                if ({w_dram_valid, w_dram_we, w_dram_addr, w_dram_be, w_busy} !==
                    {1'b1, is_wr, e_addr, e_be, 1'b1}) begin
                    n_err++;
                    $display("FAIL %s cmd[%0d]: v=%b we=%b a=%h be=%b busy=%b, want v=1 we=%b a=%h be=%b busy=1",
                             tag, i, w_dram_valid, w_dram_we, w_dram_addr, w_dram_be, w_busy, is_wr, e_addr, e_be);
                end
                if (is_wr) begin
                    n_vec++;
                    if (w_dram_wdata !== e_wd) begin
                        n_err++;
                        $display("FAIL %s wdata[%0d]: got %h want %h", tag, i, w_dram_wdata, e_wd);
                    end
                end
                @(posedge CLK); #1;
            end
            w_dram_ready = 1'b0;
            if (!is_wr) begin
                for (int j = 0; j <= rv; j++) begin
                    w_dram_rvalid = (j == rv);
                    w_dram_rdata  = (j == rv) ? rword : $urandom;
                    @(negedge CLK);
                    n_vec++;
                    if ({w_dram_valid, w_busy, w_resp_valid} !== 3'b010) begin
                        n_err++;
                        $display("FAIL %s wait_r[%0d]: valid=%b busy=%b resp=%b, want 0 1 0",
                                 tag, j, w_dram_valid, w_busy, w_resp_valid);
                    end
                    @(posedge CLK); #1;
                end
                w_dram_rvalid = 1'b0;
            end
            if (!b2b) begin w_req_re = 1'b0; w_req_we = 1'b0; end
            @(negedge CLK);
            n_vec++;
            if ({w_resp_valid, w_busy, w_misaligned, w_dram_valid} !== 4'b1000) begin
                n_err++;
                $display("FAIL %s done: resp=%b busy=%b mis=%b valid=%b, want 1 0 0 0",
                         tag, w_resp_valid, w_busy, w_misaligned, w_dram_valid);
            end
            if (!is_wr) begin
                e_rd = exp_q.pop_front();
                n_vec++;
                if (w_rdata !== e_rd) begin
                    n_err++;
                    $display("FAIL %s rdata: got %h want %h", tag, w_rdata, e_rd);
                end
            end
        end
        @(posedge CLK); #1;
        if (!b2b) begin
            @(negedge CLK);
            n_vec++;
            if ({w_resp_valid, w_misaligned, w_busy, w_dram_valid} !== 4'b0000) begin
                n_err++;
                $display("FAIL %s idle_after: resp=%b mis=%b busy=%b valid=%b, want 0 0 0 0",
                         tag, w_resp_valid, w_misaligned, w_busy, w_dram_valid);
            end
            @(posedge CLK); #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1; w_req_re = 1'b1; w_req_addr = 32'h8000_0010; w_req_ctrl = 3'b010;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_vec++;
        if ({w_busy, w_dram_valid, w_resp_valid, w_misaligned, w_dram_we} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl: busy=%b valid=%b resp=%b mis=%b we=%b, want all 0",
                     w_busy, w_dram_valid, w_resp_valid, w_misaligned, w_dram_we);
        end
        n_vec++;
        if ({w_rdata, w_dram_addr, w_dram_wdata, w_dram_be} !== 100'b0) begin
            n_err++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%b, want all 0",
                     w_rdata, w_dram_addr, w_dram_wdata, w_dram_be);
        end
        w_req_re = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({w_busy, w_dram_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release: busy=%b valid=%b, want 0 0", w_busy, w_dram_valid);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_load_word();
        run_txn(1, 0, 32'h8000_0010, 3'b010, 32'h0, 32'h1234_5678, 0, 1, 0, "lw");
        run_txn(1, 0, 32'h8000_0020, 3'b010, 32'h0, 32'hCAFE_F00D, 0, 0, 0, "lw_minlat");
    endtask

    task automatic test_load_ext();
        run_txn(1, 0, 32'h8000_0003, 3'b000, 32'h0, 32'h80FF_FFFF, 0, 0, 0, "lb");
        run_txn(1, 0, 32'h8000_0003, 3'b100, 32'h0, 32'h80FF_FFFF, 1, 0, 0, "lbu");
        run_txn(1, 0, 32'h8000_0002, 3'b001, 32'h0, 32'h8001_1234, 0, 2, 0, "lh");
        run_txn(1, 0, 32'h8000_0002, 3'b101, 32'h0, 32'h8001_1234, 0, 0, 0, "lhu");
        run_txn(1, 0, 32'h8000_0001, 3'b000, 32'h0, 32'h1234_7F56, 0, 0, 0, "lb_pos");
    endtask

    task automatic test_store_lanes();
        run_txn(0, 1, 32'h8000_0002, 3'b001, 32'h0000_ABCD, 32'h0, 0, 0, 0, "sh");
        for (int k = 0; k < 4; k++)
            run_txn(0, 1, 32'h8000_0100 + k, 3'b000, 32'h1234_56A5, 32'h0, 0, 0, 0, "sb");
        run_txn(0, 1, 32'h8000_0200, 3'b001, 32'h5555_1357, 32'h0, 0, 0, 0, "sh_lo");
        run_txn(0, 1, 32'h8000_0300, 3'b010, 32'hDEAD_0001, 32'h0, 0, 0, 0, "sw");
    endtask

    task automatic test_misaligned();
        run_txn(1, 0, 32'h8000_0001, 3'b010, 32'h0, 32'h0, 0, 0, 0, "mis_lw");
        run_txn(1, 0, 32'h8000_0003, 3'b101, 32'h0, 32'h0, 0, 0, 0, "mis_lhu");
        run_txn(0, 1, 32'h8000_0002, 3'b010, 32'h1, 32'h0, 0, 0, 0, "mis_sw");
        run_txn(1, 0, 32'h8000_0000, 3'b011, 32'h0, 32'h0, 0, 0, 0, "bad_ctrl011");
        run_txn(1, 0, 32'h8000_0000, 3'b110, 32'h0, 32'h0, 0, 0, 0, "bad_ctrl110");
    endtask

    task automatic test_ready_stall();
        run_txn(0, 1, 32'h8000_0040, 3'b010, 32'h0BAD_F00D, 32'h0, 10, 0, 0, "stall_sw");
        run_txn(1, 0, 32'h8000_0044, 3'b010, 32'h0, 32'h7777_1111, 10, 3, 0, "stall_lw");
    endtask

    task automatic test_priority();
        run_txn(1, 1, 32'h8000_0050, 3'b000, 32'h0000_0042, 32'h0, 1, 0, 0, "re_we_both");
    endtask

    task automatic test_back_to_back();
        run_txn(1, 0, 32'h8000_0060, 3'b010, 32'h0, 32'h0101_0101, 0, 0, 1, "b2b_0");
        run_txn(0, 1, 32'h8000_0066, 3'b001, 32'h0000_BEEF, 32'h0, 0, 0, 1, "b2b_1");
        run_txn(1, 0, 32'h8000_0067, 3'b100, 32'h0, 32'hF0E0_D0C0, 0, 0, 0, "b2b_2");
    endtask

    task automatic test_reset_midop();
        // reset while in REQ: valid must drop on the next edge
        w_req_we = 1'b1; w_req_addr = 32'h8000_0070; w_req_ctrl = 3'b010; w_req_wdata = 32'h1;
        @(posedge CLK); #1;
        RST = 1'b1; w_req_we = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (w_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_req_busy: got %b want 0", w_busy);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({w_dram_valid, w_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_req_drop: valid=%b busy=%b want 0 0", w_dram_valid, w_busy);
        end
        @(posedge CLK); #1;
        // reset while in WAIT_R, then a stray rvalid in IDLE
        w_req_re = 1'b1; w_req_addr = 32'h8000_0074; w_req_ctrl = 3'b010;
        @(posedge CLK); #1;
        w_dram_ready = 1'b1;
        @(posedge CLK); #1;
        w_dram_ready = 1'b0; RST = 1'b1; w_req_re = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0; w_dram_rvalid = 1'b1; w_dram_rdata = 32'hA5A5_5A5A;
        @(negedge CLK);
        n_vec++;
        if ({w_dram_valid, w_busy, w_resp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_wait_idle: valid=%b busy=%b resp=%b want 0 0 0", w_dram_valid, w_busy, w_resp_valid);
        end
        @(posedge CLK); #1;
        w_dram_rvalid = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({w_resp_valid, w_rdata} !== 33'b0) begin
            n_err++;
            $display("FAIL rst_stray_rvalid: resp=%b rdata=%h want 0 00000000", w_resp_valid, w_rdata);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        logic [2:0]  c;
        logic [31:0] a;
        int          sel;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 2);
            a   = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            if (sel == 0) begin
                c = 3'($urandom_range(0, 7));
                if ((c == 3'b011 || c[2:1] == 2'b11) && $urandom_range(0, 1) == 0) c = 3'b010;
            end else begin
                c = 3'($urandom_range(0, 3));
                if (c == 3'b011 && $urandom_range(0, 1) == 0) c = 3'b010;
                if ($urandom_range(0, 9) == 0) c = 3'b110;
            end
            run_txn(sel != 1, sel != 0, a, c, $urandom, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 1), "rand");
        end
        w_req_re = 1'b0; w_req_we = 1'b0;
        @(posedge CLK); #1;
    endtask

`ifdef BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        w_req_re = 1'b1; w_req_addr = 32'h8000_0080; w_req_ctrl = 3'b010;
        @(posedge CLK); #1;
        w_dram_ready = 1'b1;
        k = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge CLK); #1;
            w_dram_ready = 1'b0;
            k++;
            @(negedge CLK);
            if (w_resp_valid) break;
        end
        w_req_re = 1'b0;
        n_vec++;
        if (k !== 16 || w_resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_latency: resp=%b after %0d cycles, want resp=1 after 16", w_resp_valid, k);
        end
        n_vec++;
        if ({w_rdata, w_timeout} !== {32'hDEAD_BEEF, 1'b1}) begin
            n_err++;
            $display("FAIL timeout_data: rdata=%h timeout=%b want deadbeef 1", w_rdata, w_timeout);
        end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_store_lanes();
        test_misaligned();
        test_ready_stall();
        test_priority();
        test_back_to_back();
        test_reset_midop();
        test_random();
`ifdef BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
